// File: rtl/fa_test_pkg.sv
// rtl/fa_test_pkg.sv - shared states, constants and reference function for the full-adder self-test
package fa_test_pkg;

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   localparam int NUM_VECTORS = 8;
   localparam logic [2:0] LAST_VEC = 3'(NUM_VECTORS - 1);

   // vec is {A,B,Cin}; result is {S,Cout}
   function automatic logic [1:0] fa_expected(input logic [2:0] vec);
      return {^vec, (vec[2] & vec[1]) | (vec[2] & vec[0]) | (vec[1] & vec[0])};
   endfunction

endpackage

// File: rtl/fa_golden_model.sv
// rtl/fa_golden_model.sv - combinational reference full adder
module fa_golden_model
   import fa_test_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign {s, cout} = fa_expected({a, b, cin});

endmodule

// File: rtl/fa_selftest_checker.sv
// rtl/fa_selftest_checker.sv - sweeps all 8 vectors through a full adder and checks the responses
module fa_selftest_checker
   import fa_test_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int ERR_W         = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             a_o,
   output logic             b_o,
   output logic             cin_o,
   input  logic             s_i,
   input  logic             cout_i,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [2:0]       first_fail_vec,
   output logic             first_fail_valid
);

   localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

   state_t           state, state_n;
   logic [2:0]       vec, vec_n;
   logic [2:0]       drv, drv_n;
   logic [7:0]       cnt, cnt_n;
   logic [ERR_W-1:0] err, err_n;
   logic [2:0]       ffv, ffv_n;
   logic             ffval, ffval_n;
   logic             exp_s, exp_cout;
   logic             mismatch;

   fa_golden_model u_golden (
      .a    (vec[2]),
      .b    (vec[1]),
      .cin  (vec[0]),
      .s    (exp_s),
      .cout (exp_cout)
   );

   assign mismatch = (s_i != exp_s) || (cout_i != exp_cout);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         vec   <= '0;
         drv   <= '0;
         cnt   <= '0;
         err   <= '0;
         ffv   <= '0;
         ffval <= 1'b0;
      end else begin
         state <= state_n;
         vec   <= vec_n;
         drv   <= drv_n;
         cnt   <= cnt_n;
         err   <= err_n;
         ffv   <= ffv_n;
         ffval <= ffval_n;
      end
   end

   always_comb begin
      state_n = state;
      vec_n   = vec;
      cnt_n   = cnt;
      err_n   = err;
      ffv_n   = ffv;
      ffval_n = ffval;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_n = SETTLE;
               vec_n   = '0;
               cnt_n   = RELOAD;
               err_n   = '0;
               ffv_n   = '0;
               ffval_n = 1'b0;
            end
         end
         SETTLE: begin
            if (cnt == 8'd0) state_n = SAMPLE;
            else             cnt_n   = cnt - 8'd1;
         end
         SAMPLE: begin
            // S and Cout both wrong on one vector still counts once
            if (mismatch) begin
               if (err != '1) err_n = err + ERR_W'(1);
               if (!ffval) begin
                  ffv_n   = vec;
                  ffval_n = 1'b1;
               end
            end
            if (vec == LAST_VEC) begin
               state_n = DONE;
            end else begin
               state_n = SETTLE;
               vec_n   = vec + 3'd1;
               cnt_n   = RELOAD;
            end
         end
         default: state_n = IDLE;
      endcase
      // Drive pins follow the vector only while a sweep is running
      drv_n = (state_n == SETTLE || state_n == SAMPLE) ? vec_n : 3'b000;
   end

   assign {a_o, b_o, cin_o}  = drv;
   assign busy               = (state == SETTLE) || (state == SAMPLE);
   assign done               = (state == DONE);
   assign pass               = done && (err == '0);
   assign err_cnt            = err;
   assign first_fail_vec     = ffv;
   assign first_fail_valid   = ffval;

endmodule

// File: doc/fa_selftest_checker.md
Name: fa_selftest_checker

Overview:
- Synthesizable self-test engine for the single-bit full adder (ports A, B, Cin -> S, Cout).
- Drives all 8 input vectors to the adder and reads back S/Cout after a programmable settle time.
- Compares each response against a golden model and reports pass/fail, an error count and the first failing vector.
- Sits beside the adder instance as an on-chip replacement for the simulation-only stimulus bench.

Parameters:
SETTLE_CYCLES, 4, cycles each vector is held before sampling; legal range 1..255 (0 illegal)
ERR_W, 4, width of the saturating error counter

Ports:
clk  in  1  single clock
rst  in  1  synchronous reset, active-high
start  in  1  begin a sweep; sampled only in IDLE or DONE
a_o  out  1  drives adder A
b_o  out  1  drives adder B
cin_o  out  1  drives adder Cin
s_i  in  1  adder S readback
cout_i  in  1  adder Cout readback
busy  out  1  sweep in progress
done  out  1  sweep complete; held until next start or rst
pass  out  1  valid when done=1; 1 iff err_cnt==0
err_cnt  out  ERR_W  mismatching vectors, saturates at all-ones
first_fail_vec  out  3  {A,B,Cin} of the first mismatching vector
first_fail_valid  out  1  first_fail_vec holds a captured value

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, vec=0, a_o=b_o=cin_o=0, busy=0, done=0, pass=0, err_cnt=0, first_fail_vec=0, first_fail_valid=0.
- rst asserted mid-sweep aborts on the next clock edge and restores all reset values. No partial results are retained.
- Drive outputs are registered: {a_o,b_o,cin_o} = vec[2:0], so A is the MSB. Vector order is 0,1,...,7.
- Golden model: exp_s = ^vec; exp_cout = majority(vec[2],vec[1],vec[0]).
- IDLE:
  - start=1 -> SETTLE. On that edge: vec=0, settle counter=SETTLE_CYCLES-1, busy=1, done=0, err_cnt=0, first_fail_valid=0, first_fail_vec=0.
- SETTLE:
  - Outputs hold vec. The counter decrements each cycle.
  - When counter==0 -> SAMPLE.
  - The state lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle):
  - Compare {s_i,cout_i} with {exp_s,exp_cout}.
  - On mismatch: err_cnt increments unless it is all-ones. If first_fail_valid==0, capture first_fail_vec=vec and set first_fail_valid=1.
  - If vec==7 -> DONE. Otherwise vec increments, counter reloads to SETTLE_CYCLES-1, and the next state is SETTLE.
- DONE:
  - busy=0, done=1, pass=(err_cnt==0). Drive outputs return to 0.
  - start=1 -> same action as the start transition from IDLE.
- Latency:
  - busy is high for exactly 8*(SETTLE_CYCLES+1) cycles (40 at default).
  - done rises on the edge after the SAMPLE of vector 7.
- start while busy is ignored; no restart, no queuing.
- A mismatch on both S and Cout in the same vector counts as one error.
- pass is 0 whenever done=0.

Decomposition:
- Shared package fa_test_pkg:
  - state enum {IDLE, SETTLE, SAMPLE, DONE}
  - NUM_VECTORS=8
  - function fa_expected(vec[2:0]) returning {s,cout}
- One natural sub-module: fa_golden_model, a combinational reference of {S,Cout} from {A,B,Cin}. It is reused by the checker and by the bench scoreboard.

Test Plan:
- Correct adder connected, default params, start pulse -> busy 40 cycles; done=1, pass=1, err_cnt=0, first_fail_valid=0.
- Cout stuck-at-0 -> err_cnt=4 (vectors 3,5,6,7), first_fail_vec=3, pass=0.
- S inverted -> err_cnt=8, first_fail_vec=0. Rerun with ERR_W=2 -> err_cnt=3 (saturated).
- Correct adder, SETTLE_CYCLES=1 -> busy 16 cycles. Sample inputs must match drive outputs with no stale-vector errors.
- rst asserted at cycle 10 of a sweep -> next cycle all outputs at reset values. A fresh start then completes with pass=1.
- start held high throughout the sweep -> single sweep, no restart before done. Start in DONE clears err_cnt and done and reruns; restart works both when the prior sweep had errors (injected fault) and when it was clean.
